mem_stage: RTL and testbench

Memory-access stage of the CPU pipeline, between the EX/MEM register and the `mem_wb` register. Accepts one instruction at a time from EX/MEM and issues loads/stores to data memory over a request/grant/rvalid handshake. Aligns and sign/zero-extends load data and presents the result, ALU value and writeback controls to `mem_wb`. Stalls upstream while a memory transaction is outstanding and feeds bubbles downstream meanwhile.

---
 rtl/mem_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/gnt/rvalid bus, formats load data and bubbles mem_wb while busy.
// Optional MEM_STAGE_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and raise misalign_err instead.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_y_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        regWrite_in,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic [2:0]  funct3_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_data,
  output logic [31:0] alu_y,
  output logic [4:0]  rd,
  output logic        regWrite,
  output logic        memRead,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [4:0]    rd_q, rd_d;
  logic          regw_q, regw_d;
  logic          load_q, load_d;
  logic [2:0]    f3_q, f3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
  logic          merr_q, merr_d;

  logic mem_op;
  logic misalign_in;

  assign mem_op = valid_in & (memRead_in | memWrite_in);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misalign_in = ((funct3_in[1:0] == 2'b01) && alu_y_in[0]) ||
                       ((funct3_in[1:0] == 2'b10) && (alu_y_in[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  function automatic logic [31:0] load_fmt(input logic [31:0] d, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return d;
    endcase
  endfunction

  // Half-word lanes use only off[1]; words always use all four lanes.
  function automatic logic [3:0] be_fmt(input logic [1:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_fmt(input logic [31:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    regw_d  = regw_q;
    load_d  = load_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    berr_d  = berr_q;
    merr_d  = merr_q;

    stall        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = 32'b0;
    dmem_be      = 4'b0;
    dmem_wdata   = 32'b0;
    mem_data     = 32'b0;
    alu_y        = 32'b0;
    rd           = 5'b0;
    regWrite     = 1'b0;
    memRead      = 1'b0;
    bus_err      = 1'b0;
    misalign_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          addr_d  = alu_y_in;
          sdata_d = store_data_in;
          rd_d    = rd_in;
          regw_d  = regWrite_in;
          load_d  = memRead_in;
          f3_d    = funct3_in;
          rdata_d = 32'b0;
          cnt_d   = '0;
          berr_d  = 1'b0;
          merr_d  = misalign_in;
          if (misalign_in) begin
            state_d = DONE;
          end else begin
            dmem_req   = 1'b1;
            dmem_we    = ~memRead_in;
            dmem_addr  = {alu_y_in[31:2], 2'b00};
            dmem_be    = be_fmt(alu_y_in[1:0], funct3_in);
            dmem_wdata = wdata_fmt(store_data_in, funct3_in);
            if (dmem_gnt) state_d = memRead_in ? WAIT : DONE;
            else          state_d = REQ;
          end
        end else begin
          alu_y    = alu_y_in;
          rd       = rd_in;
          regWrite = regWrite_in;
          memRead  = memRead_in;
        end
      end
      REQ: begin
        stall      = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = ~load_q;
        dmem_addr  = {addr_q[31:2], 2'b00};
        dmem_be    = be_fmt(addr_q[1:0], f3_q);
        dmem_wdata = wdata_fmt(sdata_q, f3_q);
        if (dmem_gnt) state_d = load_q ? WAIT : DONE;
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          rdata_d = load_fmt(dmem_rdata, addr_q[1:0], f3_q);
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        alu_y    = addr_q;
        rd       = rd_q;
        regWrite = regw_q & ~berr_q & ~merr_q;
        memRead  = load_q;
        mem_data = rdata_q;
        bus_err  = berr_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        misalign_err = merr_q;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pass-through paths would otherwise leak inputs while reset is held.
    if (rst) begin
      stall        = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      dmem_addr    = 32'b0;
      dmem_be      = 4'b0;
      dmem_wdata   = 32'b0;
      mem_data     = 32'b0;
      alu_y        = 32'b0;
      rd           = 5'b0;
      regWrite     = 1'b0;
      memRead      = 1'b0;
      bus_err      = 1'b0;
      misalign_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'b0;
      sdata_q <= 32'b0;
      rdata_q <= 32'b0;
      rd_q    <= 5'b0;
      regw_q  <= 1'b0;
      load_q  <= 1'b0;
      f3_q    <= 3'b0;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      regw_q  <= regw_d;
      load_q  <= load_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
      merr_q  <= merr_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs driven after each falling edge, outputs checked 1ns later, writeback results scoreboarded.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_y_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic        regWrite_in;
  logic        memRead_in;
  logic        memWrite_in;
  logic [2:0]  funct3_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_data;
  logic [31:0] alu_y;
  logic [4:0]  rd;
  logic        regWrite;
  logic        memRead;
  logic        bus_err;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_y;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memRead;
    logic        bus_err;
    logic        misalign_err;
  } exp_t;

  exp_t sb[$];

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_y_in(alu_y_in),
    .store_data_in(store_data_in), .rd_in(rd_in), .regWrite_in(regWrite_in),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in), .funct3_in(funct3_in),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_data(mem_data),
    .alu_y(alu_y), .rd(rd), .regWrite(regWrite), .memRead(memRead),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] r, input logic rw, input logic mr,
                       input logic mw, input logic [2:0] f3);
    valid_in = v; alu_y_in = a; store_data_in = sd; rd_in = r;
    regWrite_in = rw; memRead_in = mr; memWrite_in = mw; funct3_in = f3;
  endtask

  task automatic bus(input logic g, input logic rv, input logic [31:0] rdat);
    dmem_gnt = g; dmem_rvalid = rv; dmem_rdata = rdat;
  endtask

  task automatic push(input logic [31:0] md, input logic [31:0] ay, input logic [4:0] r,
                      input logic rw, input logic mr, input logic be, input logic me);
    exp_t e;
    e = '{mem_data: md, alu_y: ay, rd: r, regWrite: rw, memRead: mr,
          bus_err: be, misalign_err: me};
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_mem_data"}, mem_data, e.mem_data);
    chk({tag, "_alu_y"}, alu_y, e.alu_y);
    chk({tag, "_rd"}, 32'(rd), 32'(e.rd));
    chk({tag, "_regWrite"}, 32'(regWrite), 32'(e.regWrite));
    chk({tag, "_memRead"}, 32'(memRead), 32'(e.memRead));
    chk({tag, "_bus_err"}, 32'(bus_err), 32'(e.bus_err));
    chk({tag, "_misalign_err"}, 32'(misalign_err), 32'(e.misalign_err));
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd1);
    chk({tag, "_bubble"}, {mem_data | alu_y} | 32'({rd, regWrite, memRead}), 32'd0);
  endtask

  task automatic check_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(dmem_we), 32'(we));
    chk({tag, "_addr"}, dmem_addr, addr);
    if (we) begin
      chk({tag, "_be"}, 32'(dmem_be), 32'(be));
      chk({tag, "_wdata"}, dmem_wdata, wd);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus(0, 0, 0);

    // Reset: outputs held at zero even with a live load presented.
    @(negedge clk);
    drive(1, 32'h1234, 0, 5, 1, 1, 0, 3'b010);
    bus(1, 1, 32'hDEADBEEF);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_outs", alu_y | 32'({rd, regWrite, memRead}), 0);

    @(negedge clk);
    rst = 1'b0;
    bus(0, 0, 0);

    // ALU op: zero-latency pass-through.
    drive(1, 32'h1234, 0, 5, 1, 0, 0, 3'b000);
    push(0, 32'h1234, 5, 1, 0, 0, 0);
    #1;
    chk("alu_req", 32'(dmem_req), 0);
    check_out("alu");

    // LB at 0x103, gnt immediate, rvalid next cycle.
    @(negedge clk);
    drive(1, 32'h103, 0, 7, 1, 1, 0, 3'b000);
    bus(1, 0, 0);
    push(32'hFFFFFF80, 32'h103, 7, 1, 1, 0, 0);
    #1;
    check_bubble("lb_idle");
    check_req("lb_idle", 0, 32'h100, 0, 0);
    @(negedge clk);
    bus(0, 1, 32'h80AABBCC);
    #1;
    check_bubble("lb_wait");
    chk("lb_wait_req", 32'(dmem_req), 0);
    @(negedge clk);
    bus(0, 0, 0);
    #1;
    check_out("lb_done");

    // SH at 0x202, gnt on the fourth request cycle; request must hold steady.
    @(negedge clk);
    drive(1, 32'h202, 32'h0000BEEF, 3, 0, 0, 1, 3'b001);
    push(0, 32'h202, 3, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus(i == 3, 0, 0);
      #1;
      check_bubble($sformatf("sh_req%0d", i));
      check_req($sformatf("sh_req%0d", i), 1, 32'h200, 4'b1100, 32'hBEEFBEEF);
      @(negedge clk);
    end
    bus(0, 0, 0);
    #1;
    chk("sh_done_req", 32'(dmem_req), 0);
    check_out("sh_done");

    // SB at 0x001, immediate gnt.
    @(negedge clk);
    drive(1, 32'h001, 32'h12345678, 2, 0, 0, 1, 3'b000);
    bus(1, 0, 0);
    push(0, 32'h001, 2, 0, 0, 0, 0);
    #1;
    check_req("sb", 1, 32'h0, 4'b0010, 32'h78787878);
    @(negedge clk);
    bus(0, 0, 0);
    #1;
    check_out("sb_done");

    // LW with no rvalid: 16 WAIT cycles then bus error.
    @(negedge clk);
    drive(1, 32'h40, 0, 9, 1, 1, 0, 3'b010);
    bus(1, 0, 0);
    push(0, 32'h40, 9, 0, 1, 1, 0);
    #1;
    check_req("lwto", 0, 32'h40, 0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus(0, 0, 0);
      #1;
      chk($sformatf("lwto_wait%0d_stall", i), 32'(stall), 1);
      chk($sformatf("lwto_wait%0d_berr", i), 32'(bus_err), 0);
    end
    @(negedge clk);
    #1;
    check_out("lwto_done");

    // LHU at 0x302: rvalid in the final WAIT cycle beats the timeout.
    @(negedge clk);
    drive(1, 32'h302, 0, 11, 1, 1, 0, 3'b101);
    bus(1, 0, 0);
    push(32'h0000ABCD, 32'h302, 11, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus(0, i == 15, 32'hABCD1234);
      #1;
      chk($sformatf("lhu_wait%0d_stall", i), 32'(stall), 1);
    end
    @(negedge clk);
    bus(0, 0, 0);
    #1;
    check_out("lhu_done");

    // LW at 0x102: trap when enabled, otherwise a word load from 0x100.
    @(negedge clk);
    drive(1, 32'h102, 0, 4, 1, 1, 0, 3'b010);
    bus(1, 0, 0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    push(0, 32'h102, 4, 0, 1, 0, 1);
    #1;
    check_bubble("lwmis_idle");
    chk("lwmis_req", 32'(dmem_req), 0);
`else
    push(32'h11223344, 32'h102, 4, 1, 1, 0, 0);
    #1;
    check_req("lwmis", 0, 32'h100, 0, 0);
    @(negedge clk);
    bus(0, 1, 32'h11223344);
    #1;
    check_bubble("lwmis_wait");
`endif
    @(negedge clk);
    bus(0, 0, 0);
    #1;
    check_out("lwmis_done");

    // Reset during WAIT, then a stale rvalid that must be ignored.
    @(negedge clk);
    drive(1, 32'h500, 0, 6, 1, 1, 0, 3'b010);
    bus(1, 0, 0);
    @(negedge clk);
    bus(0, 0, 0);
    #1;
    chk("rstw_wait_stall", 32'(stall), 1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_outs", mem_data | alu_y | 32'({rd, regWrite, memRead, bus_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    bus(0, 1, 32'hCAFEF00D);
    #1;
    chk("rstw_late_stall", 32'(stall), 0);
    @(negedge clk);
    bus(0, 0, 0);
    #1;
    chk("rstw_idle_stall", 32'(stall), 0);
    chk("rstw_idle_mem_data", mem_data, 0);

    // Next instruction handled normally: LBU at 0x001.
    drive(1, 32'h001, 0, 8, 1, 1, 0, 3'b100);
    bus(1, 0, 0);
    push(32'h0000005A, 32'h001, 8, 1, 1, 0, 0);
    #1;
    check_req("lbu", 0, 32'h0, 0, 0);
    @(negedge clk);
    bus(0, 1, 32'h00005A00);
    #1;
    check_bubble("lbu_wait");
    @(negedge clk);
    bus(0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_out("lbu_done");

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
